// File: rtl/mul_unit.sv
// mul_unit: iterative 32-bit shift-add multiply / multiply-accumulate.
// Retires one multiplier bit per cycle and stops as soon as the remaining
// multiplier bits are zero. The result goes back through the register
// file's single write port as a one-cycle w_en pulse, with N/Z flags.
module mul_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mla,
  input  logic [3:0]  dst_addr,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] op_c,
  output logic        busy,
  output logic        w_en,
  output logic [3:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        n_flag,
  output logic        z_flag
);

  typedef enum logic [1:0] {IDLE, ACC, RUN, WB} state_t;

  // Working set of an in-flight operation.
  typedef struct packed {
    logic [31:0] mcand;
    logic [31:0] mult;
    logic [31:0] prod;
    logic [3:0]  dst;
    logic [5:0]  cnt;
  } work_t;

  state_t state, state_nxt;
  work_t  wk, wk_nxt;

  assign busy = (state != IDLE);

  // State and working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wk    <= '0;
    end else begin
      state <= state_nxt;
      wk    <= wk_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    wk_nxt    = wk;
    case (state)
      IDLE: begin
        if (start) begin
          wk_nxt.mcand = op_a;
          wk_nxt.mult  = op_b;
          wk_nxt.dst   = dst_addr;
          wk_nxt.prod  = '0;
          wk_nxt.cnt   = '0;
          if (mla)            state_nxt = ACC;
          else if (op_b == '0) state_nxt = WB;
          else                state_nxt = RUN;
        end
      end
      ACC: begin
        // op_c arrives on the register file's second read, one cycle late.
        wk_nxt.prod = op_c;
        state_nxt   = (wk.mult == '0) ? WB : RUN;
      end
      RUN: begin
        // Carry-out of the add is dropped; only the low word is kept.
        if (wk.mult[0]) wk_nxt.prod = wk.prod + wk.mcand;
        wk_nxt.mcand = wk.mcand << 1;
        wk_nxt.mult  = wk.mult >> 1;
        wk_nxt.cnt   = wk.cnt + 6'd1;
        if (wk_nxt.mult == '0 || wk_nxt.cnt == 6'd32) state_nxt = WB;
      end
      WB: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Write port: registered on entry to WB so w_en is high exactly for the
  // WB cycle; address/data/flags hold until the next write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_en    <= 1'b0;
      rd_addr <= '0;
      rd_data <= '0;
      n_flag  <= 1'b0;
      z_flag  <= 1'b0;
    end else begin
      w_en <= (state_nxt == WB);
      if (state_nxt == WB) begin
        rd_addr <= wk_nxt.dst;
        rd_data <= wk_nxt.prod;
        n_flag  <= wk_nxt.prod[31];
        z_flag  <= (wk_nxt.prod == '0);
      end
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed vectors for mul_unit with hand-computed results.
module tb_mul_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mla;
  logic [3:0]  dst_addr;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] op_c;
  logic        busy;
  logic        w_en;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        n_flag;
  logic        z_flag;

  int errs   = 0;
  int checks = 0;
  int wr_cnt = 0;

  mul_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mla(mla),
    .dst_addr(dst_addr), .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .busy(busy), .w_en(w_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .n_flag(n_flag), .z_flag(z_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count register-file writes (one per w_en pulse).
  always @(negedge clk) if (w_en) wr_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, wait for its write-back and check it.
  task automatic run_op(input string tag, input logic m, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c,
                        input logic [3:0] d, input logic [31:0] exp, input int lat);
    int n;
    int w0;
    w0 = wr_cnt;
    start = 1'b1; mla = m; op_a = a; op_b = b; dst_addr = d; op_c = 32'hDEAD_BEEF;
    tick();                        // edge k
    start = 1'b0; op_a = 32'h5A5A_5A5A; op_b = 32'hA5A5_A5A5; op_c = c;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!w_en && n < 40) begin
      tick();
      n++;
      if (n == 1) op_c = ~c;       // op_c only matters at edge k+1
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_addr"}, 32'(rd_addr), 32'(d));
    chk({tag, "_data"}, rd_data, exp);
    chk({tag, "_n"}, 32'(n_flag), 32'(exp[31]));
    chk({tag, "_z"}, 32'(z_flag), 32'(exp == 32'd0));
    tick();
    chk({tag, "_wen_off"}, 32'(w_en), 32'd0);
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    chk({tag, "_hold"}, rd_data, exp);
    chk({tag, "_nwr"}, wr_cnt - w0, 1);
  endtask

  initial begin
    int n;
    int w0;
    rst_n = 1'b0; start = 1'b0; mla = 1'b0; dst_addr = '0;
    op_a = '0; op_b = '0; op_c = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wen", 32'(w_en), 32'd0);
    chk("rst_addr", 32'(rd_addr), 32'd0);
    chk("rst_data", rd_data, 32'd0);
    chk("rst_n", 32'(n_flag), 32'd0);
    chk("rst_z", 32'(z_flag), 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("mul3x5",   1'b0, 32'd3,          32'd5,          32'd0,   4'd2,  32'd15,         3);
    run_op("mla7x6",   1'b1, 32'd7,          32'd6,          32'd100, 4'd4,  32'd142,        4);
    run_op("mulfull",  1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,   4'd5,  32'd1,          32);
    run_op("mulneg",   1'b0, 32'h8000_0000,  32'd1,          32'd0,   4'd6,  32'h8000_0000,  1);
    run_op("mulzero",  1'b0, 32'h0000_1234,  32'd0,          32'd0,   4'd7,  32'd0,          0);
    run_op("mlazero",  1'b1, 32'h0000_0055,  32'd0,          32'd9,   4'd8,  32'd9,          1);
    run_op("mulwrap",  1'b0, 32'h0001_0000,  32'h0001_0000,  32'd0,   4'd15, 32'd0,          17);
    run_op("mlawrap",  1'b1, 32'hFFFF_FFFF,  32'd2,          32'd5,   4'd10, 32'd3,          3);

    // Held start: the second request must wait for the first to finish.
    w0 = wr_cnt;
    start = 1'b1; mla = 1'b0; op_a = 32'd3; op_b = 32'd5; dst_addr = 4'd2;
    tick();
    op_a = 32'd4; op_b = 32'd4; dst_addr = 4'd9;
    n = 0;
    while (!w_en && n < 40) begin tick(); n++; end
    chk("hold_lat", n, 3);
    chk("hold_addr1", 32'(rd_addr), 32'd2);
    chk("hold_data1", rd_data, 32'd15);
    tick();
    n = 0;
    while (!w_en && n < 12) begin tick(); n++; end
    start = 1'b0;
    chk("hold_seen2", 32'(w_en), 32'd1);
    chk("hold_addr2", 32'(rd_addr), 32'd9);
    chk("hold_data2", rd_data, 32'd16);
    tick(); tick();
    chk("hold_nwr", wr_cnt - w0, 2);

    // Reset in the middle of RUN aborts the operation with no write.
    w0 = wr_cnt;
    start = 1'b1; mla = 1'b0; op_a = 32'h0000_FFFF; op_b = 32'h0000_FFFF; dst_addr = 4'd3;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("abort_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wen", 32'(w_en), 32'd0);
    chk("abort_data", rd_data, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (25) tick();
    chk("abort_nwr", wr_cnt - w0, 0);
    chk("abort_idle", 32'(busy), 32'd0);
    run_op("mul2x2", 1'b0, 32'd2, 32'd2, 32'd0, 4'd1, 32'd4, 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
